// File: rtl/l2_msg_queue.sv
// ============================================================================
// Module      : l2_msg_queue
// Description : FIFO for the L1 data cache's outbound L2 bus messages
//               (READ, WRITE, RFO, RETURN) with a valid/ready handshake on
//               both sides, silent (accept-and-discard) mode and a
//               synchronous flush driven by the cache reset command.
//               Optional per-type delivery counters and an occupancy
//               high-water mark are built when L2_MSG_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_msg_queue #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode_i,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [1:0]               in_type_i,
  input  logic [ADDR_W-1:0]        in_addr_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [1:0]               out_type_o,
  output logic [ADDR_W-1:0]        out_addr_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [4*CNT_W-1:0]       stat_cnt_o,
  output logic [$clog2(DEPTH):0]   stat_hwm_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] C_FULL_CNT = OCC_W'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  count_q, count_d;
  logic [1:0]        mem_type_q [DEPTH];
  logic [1:0]        mem_type_d [DEPTH];
  logic [ADDR_W-1:0] mem_addr_q [DEPTH];
  logic [ADDR_W-1:0] mem_addr_d [DEPTH];

  logic w_full;
  logic w_push;
  logic w_pop;

  // Handshake qualifiers; silent mode still raises in_ready_o but never stores.
  assign w_full      = (count_q == C_FULL_CNT);
  assign in_ready_o  = !w_full;
  assign out_valid_o = (count_q != '0);
  assign w_push      = in_valid_i & in_ready_o & mode_i;
  assign w_pop       = out_valid_o & out_ready_i;
  assign count_o     = count_q;

  // Head entry is forced to zero when the queue is empty.
  assign out_type_o = out_valid_o ? mem_type_q[rd_ptr_q] : 2'b00;
  assign out_addr_o = out_valid_o ? mem_addr_q[rd_ptr_q] : '0;

  // Next-state for pointers, occupancy and storage; flush overrides any handshake.
  // DEPTH is a power of two, so plain pointer increment wraps DEPTH-1 -> 0.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_type_d = mem_type_q;
    mem_addr_d = mem_addr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) begin
        mem_type_d[wr_ptr_q] = in_type_i;
        mem_addr_d[wr_ptr_q] = in_addr_i;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + OCC_W'(1);
        2'b01:   count_d = count_q - OCC_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; async reset discards every stored message at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_type_q[i] <= 2'b00;
        mem_addr_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_type_q <= mem_type_d;
      mem_addr_q <= mem_addr_d;
    end
  end

`ifdef L2_MSG_STATS_EN
  logic [CNT_W-1:0] stat_q [4];
  logic [CNT_W-1:0] stat_d [4];
  logic [OCC_W-1:0] hwm_q, hwm_d;

  // Saturating per-type delivery counters and high-water mark of post-update occupancy.
  always_comb begin
    stat_d = stat_q;
    hwm_d  = hwm_q;
    if (flush_i) begin
      for (int i = 0; i < 4; i++) stat_d[i] = '0;
      hwm_d = '0;
    end else begin
      if (w_pop && (stat_q[out_type_o] != {CNT_W{1'b1}})) begin
        stat_d[out_type_o] = stat_q[out_type_o] + CNT_W'(1);
      end
      if (count_d > hwm_q) begin
        hwm_d = count_d;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) stat_q[i] <= '0;
      hwm_q <= '0;
    end else begin
      stat_q <= stat_d;
      hwm_q  <= hwm_d;
    end
  end

  assign stat_cnt_o = {stat_q[3], stat_q[2], stat_q[1], stat_q[0]};
  assign stat_hwm_o = hwm_q;
`else
  assign stat_cnt_o = '0;
  assign stat_hwm_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_l2_msg_queue.sv
// ============================================================================
// Module      : tb_l2_msg_queue
// Description : Self-checking bench for l2_msg_queue against a queue-based
//               reference model. Statistics expectations follow
//               L2_MSG_STATS_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l2_msg_queue;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 8;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 mode_i, flush_i, in_valid_i, out_ready_i;
  logic                 in_ready_o, out_valid_o;
  logic [1:0]           in_type_i, out_type_o;
  logic [ADDR_W-1:0]    in_addr_i, out_addr_o;
  logic [3:0]           count_o, stat_hwm_o;
  logic [4*CNT_W-1:0]   stat_cnt_o;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state
  logic [ADDR_W+1:0] mq[$];
  int m_stat[4];
  int m_hwm;

  l2_msg_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_type_i(in_type_i),
    .in_addr_i(in_addr_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_type_o(out_type_o), .out_addr_o(out_addr_o), .count_o(count_o),
    .stat_cnt_o(stat_cnt_o), .stat_hwm_o(stat_hwm_o)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    mq.delete();
    for (int i = 0; i < 4; i++) m_stat[i] = 0;
    m_hwm = 0;
  endtask

  function automatic logic [4*CNT_W-1:0] exp_stat();
`ifdef L2_MSG_STATS_EN
    return {CNT_W'(m_stat[3]), CNT_W'(m_stat[2]), CNT_W'(m_stat[1]), CNT_W'(m_stat[0])};
`else
    return '0;
`endif
  endfunction

  function automatic logic [3:0] exp_hwm();
`ifdef L2_MSG_STATS_EN
    return 4'(m_hwm);
`else
    return 4'd0;
`endif
  endfunction

  // Drive one cycle of inputs (entered at a negedge), advance the model at
  // the rising edge and return at the following negedge.
  task automatic step(input bit v, input logic [1:0] t, input logic [ADDR_W-1:0] a,
                      input bit m, input bit r, input bit f);
    bit m_push, m_pop;
    logic [ADDR_W+1:0] e;
    in_valid_i = v; in_type_i = t; in_addr_i = a;
    mode_i = m; out_ready_i = r; flush_i = f;
    m_push = v && m && (mq.size() < DEPTH);
    m_pop  = r && (mq.size() != 0);
    @(posedge clk);
    if (f) begin
      model_clear();
    end else begin
      if (m_pop) begin
        e = mq.pop_front();
        if (m_stat[e[ADDR_W+1:ADDR_W]] < SAT) m_stat[e[ADDR_W+1:ADDR_W]]++;
      end
      if (m_push) mq.push_back({t, a});
      if (mq.size() > m_hwm) m_hwm = mq.size();
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 2'd0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    tests_run++;
    if (count_o !== 4'd0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ctrl: count=%0d valid=%b ready=%b, want 0/0/1", count_o, out_valid_o, in_ready_o);
    end
    tests_run++;
    if (out_type_o !== 2'd0 || out_addr_o !== '0 || stat_cnt_o !== '0 || stat_hwm_o !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_data: type=%0d addr=%h stat=%h hwm=%0d, want all 0", out_type_o, out_addr_o, stat_cnt_o, stat_hwm_o);
    end
  endtask

  task automatic test_single();
    step(1'b1, 2'd0, 32'h1000_0040, 1'b1, 1'b1, 1'b0);
    tests_run++;
    if (out_valid_o !== 1'b1 || out_type_o !== 2'd0 || out_addr_o !== 32'h1000_0040) begin
      tests_failed++;
      $display("FAIL single_head: valid=%b type=%0d addr=%h, want 1/0/10000040", out_valid_o, out_type_o, out_addr_o);
    end
    step(1'b0, 2'd0, '0, 1'b1, 1'b1, 1'b0);
    tests_run++;
    if (count_o !== 4'd0 || out_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_pop: count=%0d valid=%b, want 0/0", count_o, out_valid_o);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 2'($urandom_range(0, 3)), $urandom, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (count_o !== 4'd8 || in_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_state: count=%0d ready=%b, want 8/0", count_o, in_ready_o);
    end
    step(1'b1, 2'd3, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (count_o !== 4'd8) begin
      tests_failed++;
      $display("FAIL full_ninth: count=%0d, want 8", count_o);
    end
    for (int i = 0; i < DEPTH; i++) begin
      tests_run++;
      if ({out_type_o, out_addr_o} !== mq[0] || out_valid_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL full_order[%0d]: got %h valid=%b, want %h", i, {out_type_o, out_addr_o}, out_valid_o, mq[0]);
      end
      step(1'b0, 2'd0, '0, 1'b1, 1'b1, 1'b0);
      if (i == 0) begin
        tests_run++;
        if (in_ready_o !== 1'b1 || count_o !== 4'd7) begin
          tests_failed++;
          $display("FAIL full_free: ready=%b count=%0d, want 1/7", in_ready_o, count_o);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) step(1'b1, 2'($urandom_range(0, 3)), $urandom, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tests_run++;
      if (count_o !== 4'd3 || {out_type_o, out_addr_o} !== mq[0]) begin
        tests_failed++;
        $display("FAIL b2b[%0d]: count=%0d head=%h, want 3/%h", i, count_o, {out_type_o, out_addr_o}, mq[0]);
      end
      step(1'b1, 2'($urandom_range(0, 3)), $urandom, 1'b1, 1'b1, 1'b0);
    end
    while (mq.size() != 0) begin
      tests_run++;
      if ({out_type_o, out_addr_o} !== mq[0]) begin
        tests_failed++;
        $display("FAIL b2b_drain: head=%h, want %h", {out_type_o, out_addr_o}, mq[0]);
      end
      step(1'b0, 2'd0, '0, 1'b1, 1'b1, 1'b0);
    end
  endtask

  task automatic test_silent();
    logic [4*CNT_W-1:0] s0;
    s0 = stat_cnt_o;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'($urandom_range(0, 3)), $urandom, 1'b0, 1'b1, 1'b0);
      tests_run++;
      if (in_ready_o !== 1'b1 || count_o !== 4'd0 || out_valid_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL silent[%0d]: ready=%b count=%0d valid=%b, want 1/0/0", i, in_ready_o, count_o, out_valid_o);
      end
    end
    tests_run++;
    if (stat_cnt_o !== s0 || stat_cnt_o !== exp_stat()) begin
      tests_failed++;
      $display("FAIL silent_stats: stat=%h, want %h", stat_cnt_o, exp_stat());
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) step(1'b1, 2'($urandom_range(0, 3)), $urandom, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'd1, 32'h5555_0000, 1'b1, 1'b1, 1'b1);
    tests_run++;
    if (count_o !== 4'd0 || out_valid_o !== 1'b0 || stat_cnt_o !== '0 || stat_hwm_o !== 4'd0) begin
      tests_failed++;
      $display("FAIL flush: count=%0d valid=%b stat=%h hwm=%0d, want 0/0/0/0", count_o, out_valid_o, stat_cnt_o, stat_hwm_o);
    end
    step(1'b1, 2'd2, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (count_o !== 4'd1 || out_type_o !== 2'd2 || out_addr_o !== 32'hA5A5_0001) begin
      tests_failed++;
      $display("FAIL flush_after: count=%0d type=%0d addr=%h, want 1/2/a5a50001", count_o, out_type_o, out_addr_o);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 2'($urandom_range(0, 3)), $urandom, 1'b1, 1'b0, 1'b0);
    // asynchronous reset between clock edges
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (count_o !== 4'd0 || out_valid_o !== 1'b0 || out_addr_o !== '0 || out_type_o !== 2'd0) begin
      tests_failed++;
      $display("FAIL async_reset: count=%0d valid=%b type=%0d addr=%h, want 0", count_o, out_valid_o, out_type_o, out_addr_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tests_run++;
      if (count_o !== 4'(mq.size()) || in_ready_o !== (mq.size() < DEPTH) ||
          out_valid_o !== (mq.size() != 0) ||
          {out_type_o, out_addr_o} !== ((mq.size() != 0) ? mq[0] : '0)) begin
        tests_failed++;
        $display("FAIL random[%0d]: count=%0d ready=%b valid=%b head=%h, want count=%0d",
                 i, count_o, in_ready_o, out_valid_o, {out_type_o, out_addr_o}, mq.size());
      end
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom,
           $urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
    end
    tests_run++;
    if (stat_cnt_o !== exp_stat() || stat_hwm_o !== exp_hwm()) begin
      tests_failed++;
      $display("FAIL random_stats: stat=%h hwm=%0d, want %h/%0d", stat_cnt_o, stat_hwm_o, exp_stat(), exp_hwm());
    end
  endtask

  task automatic test_stats();
    logic [1:0] seq [6];
    seq = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3};
    step(1'b0, 2'd0, '0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, seq[i], $urandom, 1'b1, 1'b0, 1'b0);
    while (mq.size() != 0) step(1'b0, 2'd0, '0, 1'b1, 1'b1, 1'b0);
`ifdef L2_MSG_STATS_EN
    tests_run++;
    if (stat_cnt_o !== {8'd1, 8'd3, 8'd2, 8'd0} || stat_hwm_o !== 4'd6) begin
      tests_failed++;
      $display("FAIL stats_mix: stat=%h hwm=%0d, want 01030200/6", stat_cnt_o, stat_hwm_o);
    end
    for (int i = 0; i < SAT + 15; i++) step(1'b1, 2'd0, $urandom, 1'b1, 1'b1, 1'b0);
    tests_run++;
    if (stat_cnt_o[CNT_W-1:0] !== 8'hFF || stat_cnt_o !== exp_stat()) begin
      tests_failed++;
      $display("FAIL stats_sat: stat=%h, want %h", stat_cnt_o, exp_stat());
    end
`else
    tests_run++;
    if (stat_cnt_o !== '0 || stat_hwm_o !== 4'd0) begin
      tests_failed++;
      $display("FAIL stats_off: stat=%h hwm=%0d, want 0/0", stat_cnt_o, stat_hwm_o);
    end
`endif
    while (mq.size() != 0) step(1'b0, 2'd0, '0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; mode_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0;
    out_ready_i = 1'b0; in_type_i = 2'd0; in_addr_i = '0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_silent();
    test_flush();
    test_random();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
